cdb_issue_scheduler: RTL and testbench
======================================

Name: cdb_issue_scheduler

Overview:
- Issue-stage scheduler for the Tomasulo back end.
- Each cycle it decides which ready issue queues (int, mem, mult, div) may dispatch to their functional unit, so that no two results reach the Common Data Bus in the same cycle.
- It keeps a per-slot CDB ownership shift register and enforces the non-pipelined divider's busy window.
- It drives the registered CDB source select consumed by the CDB mux.

Parameters:
- LAT_INT, 1, cycles from int issue to its CDB slot (≥1)
- LAT_MEM, 1, cycles from mem issue to its CDB slot (≥1)
- LAT_MULT, 4, cycles from mult issue to its CDB slot (≥1, pipelined unit)
- LAT_DIV, 7, cycles from div issue to its CDB slot; also the divider occupancy; must be the largest latency
- DEPTH, LAT_DIV, number of ownership slots

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ready_int  in  1  int queue holds a ready instruction
- ready_mem  in  1  mem queue holds a ready instruction
- ready_mult  in  1  mult queue holds a ready instruction
- ready_div  in  1  div queue holds a ready instruction
- issue_int  out  1  grant; the int queue dispatches this cycle
- issue_mem  out  1  grant; the mem queue dispatches this cycle
- issue_mult  out  1  grant; the mult queue dispatches this cycle
- issue_div  out  1  grant; the div queue dispatches this cycle
- cdb_sel  out  3  CDB owner this cycle: 0 empty, 1 int, 2 mem, 3 mult, 4 div
- cdb_valid  out  1  high when cdb_sel != 0
- div_busy  out  1  divider occupied; blocks issue_div

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.

State:
- own[0..DEPTH-1], 3 bits each.
- rr_ptr, 1 bit: 0 prefers int, 1 prefers mem.
- div_cnt, ceil(log2(LAT_DIV+1)) bits.

Reset:
- On the rst edge: all own cleared to 0, rr_ptr=0, div_cnt=0.
- Grants are combinationally forced to 0 while rst=1.
- Reset mid-operation discards every in-flight reservation. The next cycle shows cdb_sel=0 and cdb_valid=0.

Outputs:
- cdb_sel = own[0], a registered output. cdb_valid = |own[0].
- div_busy = (div_cnt != 0).

Slot free check (combinational, cycle t):
- free(L) = (L == DEPTH) ? 1 : (own[L] == 0).
- own[L] is the slot that becomes own[L-1] after this edge.

Grant order within the cycle (combinational, no combinational loop):
1. issue_div = ready_div & !div_busy & free(LAT_DIV).
2. issue_mult = ready_mult & free(LAT_MULT) & !(issue_div & LAT_DIV == LAT_MULT).
3. int and mem: each must be ready, free(its latency), and not collide with the latency of a grant already made.
   - If both qualify and LAT_INT == LAT_MEM, only the rr_ptr-preferred one is granted.
   - If their latencies differ, both may be granted.
- At most one grant per latency value per cycle. No grant unless the corresponding ready is high.

Edge update:
- Shift: own[i] <= own[i+1] for i < DEPTH-1; own[DEPTH-1] <= 0.
- Overlay: for each granted unit with latency L, own[L-1] <= its code. Overlay wins over the shift.
- Latency: a grant in cycle t makes cdb_sel equal that unit's code in cycle t+L, for exactly one cycle.

Round robin:
- When int and mem both qualify and collide, rr_ptr toggles after the grant (the loser gets priority next time).
- rr_ptr is unchanged otherwise.

Divider counter:
- issue_div loads div_cnt <= LAT_DIV-1. Otherwise div_cnt decrements while nonzero.
- The earliest back-to-back div issue is t+LAT_DIV, the same cycle the prior div result is on the CDB.

Ready semantics:
- ready_* that drops without a grant is legal. The scheduler holds no per-request state.

Test Plan:
1. Reset, then ready_int=1 for 1 cycle at t0.
   - Required: issue_int=1 at t0; cdb_sel=1 at t0+1 only; cdb_valid mirrors it.
2. ready_int=ready_mem=1 held 4 cycles from reset.
   - Required: grants alternate int,mem,int,mem; cdb_sel=1,2,1,2 on cycles t0+1..t0+4; never both grants in one cycle.
3. ready_div=1 at t0, ready_mult=1 at t0+3.
   - Required: issue_div at t0; issue_mult at t0+3 is blocked, because own[4] already holds the div slot at t0+7; issue_mult granted at t0+4.
   - Required CDB: cdb_sel=4 at t0+7, then 3 at t0+8.
4. ready_div held 16 cycles.
   - Required: issue_div at t0, t0+7, t0+14 only; div_busy high on t0+1..t0+6; cdb_sel=4 at t0+7 and t0+14.
5. ready_mult at t0, ready_int at t0+3.
   - Required: int blocked at t0+3 because the mult slot lands at t0+4; int granted at t0+4; cdb_sel=3 at t0+4, then 1 at t0+5.
6. Issue div at t0, assert rst at t0+2 for 1 cycle.
   - Required: all grants 0 during reset; cdb_sel stays 0 through t0+8; div_busy=0 after reset; a new div is granted the cycle after reset.

Source files
------------

// File: rtl/cdb_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cdb_issue_scheduler
// Description : Issue-stage scheduler for the Tomasulo back end. Each cycle it
//               grants dispatch to the ready int/mem/mult/div issue queues so
//               that no two results reach the Common Data Bus in the same
//               cycle. A per-slot ownership shift register records which unit
//               owns each future CDB cycle. A down-counter keeps a second div
//               out of the non-pipelined divider while it is busy.
//
// Ports       : clk, rst                   clock, synchronous active-high reset
//               ready_int/mem/mult/div     issue queue holds a ready instruction
//               issue_int/mem/mult/div     dispatch grants (combinational)
//               cdb_sel[2:0]               registered CDB owner
//                                          (0 empty, 1 int, 2 mem, 3 mult, 4 div)
//               cdb_valid                  cdb_sel != 0
//               div_busy                   divider occupied
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_issue_scheduler #(
    parameter int LAT_INT  = 1,
    parameter int LAT_MEM  = 1,
    parameter int LAT_MULT = 4,
    parameter int LAT_DIV  = 7,
    parameter int DEPTH    = LAT_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready_int,
    input  logic       ready_mem,
    input  logic       ready_mult,
    input  logic       ready_div,
    output logic       issue_int,
    output logic       issue_mem,
    output logic       issue_mult,
    output logic       issue_div,
    output logic [2:0] cdb_sel,
    output logic       cdb_valid,
    output logic       div_busy
);

    localparam int       c_cnt_w        = $clog2(LAT_DIV + 1);
    localparam logic [2:0] c_code_int   = 3'd1;
    localparam logic [2:0] c_code_mem   = 3'd2;
    localparam logic [2:0] c_code_mult  = 3'd3;
    localparam logic [2:0] c_code_div   = 3'd4;

    // Compile-time latency collisions between unit pairs.
    localparam bit c_div_eq_mult = (LAT_DIV == LAT_MULT);
    localparam bit c_int_eq_div  = (LAT_INT == LAT_DIV);
    localparam bit c_int_eq_mult = (LAT_INT == LAT_MULT);
    localparam bit c_mem_eq_div  = (LAT_MEM == LAT_DIV);
    localparam bit c_mem_eq_mult = (LAT_MEM == LAT_MULT);
    localparam bit c_int_eq_mem  = (LAT_INT == LAT_MEM);

    logic [2:0]         r_own [DEPTH];
    logic               r_rr_ptr;
    logic [c_cnt_w-1:0] r_div_cnt;

    logic [DEPTH:0]     w_free;
    logic               w_g_div;
    logic               w_g_mult;
    logic               w_q_int;
    logic               w_q_mem;
    logic               w_coll;
    logic               w_g_int;
    logic               w_g_mem;

    // w_free[L]: the slot reached L cycles from now is unreserved. own[L]
    // becomes own[L-1] after this edge; slot DEPTH is always empty since
    // zeros are shifted in at the top.
    always_comb begin
        w_free = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_free[k] = (r_own[k] == 3'd0);
        end
        w_free[DEPTH] = 1'b1;
    end

    // Fixed grant order div -> mult -> int/mem, so each stage only looks at
    // grants already decided and no combinational loop forms.
    always_comb begin
        w_g_div  = !rst & ready_div & !div_busy & w_free[LAT_DIV];
        w_g_mult = !rst & ready_mult & w_free[LAT_MULT]
                 & !(w_g_div & c_div_eq_mult);
        w_q_int  = !rst & ready_int & w_free[LAT_INT]
                 & !(w_g_div & c_int_eq_div) & !(w_g_mult & c_int_eq_mult);
        w_q_mem  = !rst & ready_mem & w_free[LAT_MEM]
                 & !(w_g_div & c_mem_eq_div) & !(w_g_mult & c_mem_eq_mult);
        // Only when int and mem share a latency does the round robin decide.
        w_coll   = w_q_int & w_q_mem & c_int_eq_mem;
        w_g_int  = w_q_int & !(w_coll & r_rr_ptr);
        w_g_mem  = w_q_mem & !(w_coll & !r_rr_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_own[i] <= 3'd0;
            end
            r_rr_ptr  <= 1'b0;
            r_div_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                r_own[i] <= r_own[i + 1];
            end
            r_own[DEPTH-1] <= 3'd0;

            // Reservations are written after the shift so they take priority.
            if (w_g_div)  r_own[LAT_DIV-1]  <= c_code_div;
            if (w_g_mult) r_own[LAT_MULT-1] <= c_code_mult;
            if (w_g_int)  r_own[LAT_INT-1]  <= c_code_int;
            if (w_g_mem)  r_own[LAT_MEM-1]  <= c_code_mem;

            // Loser of a collision gets priority next time.
            if (w_coll) r_rr_ptr <= !r_rr_ptr;

            if (w_g_div) begin
                r_div_cnt <= c_cnt_w'(LAT_DIV - 1);
            end else if (r_div_cnt != '0) begin
                r_div_cnt <= r_div_cnt - c_cnt_w'(1);
            end
        end
    end

    assign issue_int  = w_g_int;
    assign issue_mem  = w_g_mem;
    assign issue_mult = w_g_mult;
    assign issue_div  = w_g_div;
    assign cdb_sel    = r_own[0];
    assign cdb_valid  = |r_own[0];
    assign div_busy   = (r_div_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_cdb_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_issue_scheduler
// Description : Directed self-checking bench for cdb_issue_scheduler. Grants
//               and div_busy are checked against per-step constants; each
//               expected grant schedules its CDB result in a scoreboard queue
//               that is matched against cdb_sel/cdb_valid every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_issue_scheduler;

    localparam int c_lat_int  = 1;
    localparam int c_lat_mem  = 1;
    localparam int c_lat_mult = 4;
    localparam int c_lat_div  = 7;

    typedef struct {
        int         due;
        logic [2:0] code;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       ready_int, ready_mem, ready_mult, ready_div;
    logic       issue_int, issue_mem, issue_mult, issue_div;
    logic [2:0] cdb_sel;
    logic       cdb_valid;
    logic       div_busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    cdb_issue_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .ready_int  (ready_int),
        .ready_mem  (ready_mem),
        .ready_mult (ready_mult),
        .ready_div  (ready_div),
        .issue_int  (issue_int),
        .issue_mem  (issue_mem),
        .issue_mult (issue_mult),
        .issue_div  (issue_div),
        .cdb_sel    (cdb_sel),
        .cdb_valid  (cdb_valid),
        .div_busy   (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc%0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle. rdy/exp_g bit order: [3] div, [2] mult, [1] mem, [0] int.
    task automatic step(input logic r, input logic [3:0] rdy,
                        input logic [3:0] exp_g, input logic exp_busy);
        logic [2:0] e;
        rst        = r;
        ready_div  = rdy[3];
        ready_mult = rdy[2];
        ready_mem  = rdy[1];
        ready_int  = rdy[0];
        @(negedge clk);
        chk("grants", {issue_div, issue_mult, issue_mem, issue_int}, exp_g);
        chk("div_busy", div_busy, exp_busy);
        e = 3'd0;
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].due == cyc) begin
                e = sb[k].code;
                sb.delete(k);
                break;
            end
        end
        chk("cdb_sel", cdb_sel, e);
        chk("cdb_valid", cdb_valid, e != 3'd0);
        if (exp_g[3]) sb.push_back('{cyc + c_lat_div,  3'd4});
        if (exp_g[2]) sb.push_back('{cyc + c_lat_mult, 3'd3});
        if (exp_g[1]) sb.push_back('{cyc + c_lat_mem,  3'd2});
        if (exp_g[0]) sb.push_back('{cyc + c_lat_int,  3'd1});
        @(posedge clk);
        #1;
        cyc++;
        // Reset throws away every in-flight reservation.
        if (r) sb.delete();
    endtask

    task automatic do_reset();
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        ready_int = 1'b0; ready_mem = 1'b0; ready_mult = 1'b0; ready_div = 1'b0;
        @(posedge clk);
        #1;

        // 1: single int issue, CDB one cycle later only.
        do_reset();
        step(1'b0, 4'b0001, 4'b0001, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);

        // 2: int and mem collide; round robin alternates.
        do_reset();
        step(1'b0, 4'b0011, 4'b0001, 1'b0);
        step(1'b0, 4'b0011, 4'b0010, 1'b0);
        step(1'b0, 4'b0011, 4'b0001, 1'b0);
        step(1'b0, 4'b0011, 4'b0010, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);

        // 3: div then mult; mult blocked at t0+3 by the div reservation.
        do_reset();
        step(1'b0, 4'b1000, 4'b1000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 1'b1);
        step(1'b0, 4'b0100, 4'b0000, 1'b1);
        step(1'b0, 4'b0100, 4'b0100, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);

        // 4: div held 16 cycles; back-to-back issue every 7 cycles.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(1'b0, (i < 16) ? 4'b1000 : 4'b0000,
                 (i % 7 == 0 && i < 16) ? 4'b1000 : 4'b0000,
                 (i % 7 != 0));
        end

        // 5: mult at t0 blocks int at t0+3.
        do_reset();
        step(1'b0, 4'b0100, 4'b0100, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0001, 4'b0000, 1'b0);
        step(1'b0, 4'b0001, 4'b0001, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);

        // 6: reset mid-flight drops the div reservation and busy window.
        do_reset();
        step(1'b0, 4'b1000, 4'b1000, 1'b0);
        step(1'b0, 4'b1000, 4'b0000, 1'b1);
        step(1'b1, 4'b1000, 4'b0000, 1'b1);
        step(1'b0, 4'b1000, 4'b1000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b0000, 4'b0000, 1'b1);
        end
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);

        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
